// File: rtl/ps2_pkg.sv
// Shared constants and frame-receiver state encoding for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  // bitCnt value while waiting for the stop bit (start=0, data=1..8, parity=9)
  localparam logic [3:0] STOP_BIT_IDX = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, 11-bit frame FSM and
// mid-frame timeout. Emits one validated byte per good frame.
//
// state | meaning
// IDLE  | waiting for a falling edge carrying a 0 start bit
// RECV  | shifting data/parity bits, timeout counter running
// DONE  | one cycle: check parity/stop, deliver byte or flag error
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int TIMEOUT_BITS   = 14
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2Clk,
  input  logic       i_ps2Data,
  output logic [7:0] o_byte,
  output logic       o_byteValid,
  output logic       o_frameError
);

  logic [1:0]              r_clk_sync;
  logic [1:0]              r_data_sync;
  logic                    r_clk_prev;
  frame_state_t            r_state;
  frame_state_t            w_next;
  logic [3:0]              r_bit_cnt;
  logic [8:0]              r_shift;
  logic                    r_stop;
  logic [TIMEOUT_BITS-1:0] r_tmo;
  logic                    r_frame_err;

  logic w_fall;
  logic w_bit;
  logic w_timeout;
  logic w_frame_ok;

  assign w_fall     = r_clk_prev & ~r_clk_sync[1];
  assign w_bit      = r_data_sync[1];
  assign w_timeout  = (r_state == ST_RECV) && !w_fall &&
                      (r_tmo == TIMEOUT_BITS'(TIMEOUT_CYCLES));
  assign w_frame_ok = (^r_shift) & r_stop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_fall && !w_bit) w_next = ST_RECV;
      ST_RECV: begin
        if (w_timeout)                                  w_next = ST_IDLE;
        else if (w_fall && (r_bit_cnt == STOP_BIT_IDX)) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_clk_sync  <= '0;
      r_data_sync <= '0;
      r_clk_prev  <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_stop      <= 1'b0;
      r_tmo       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2Clk};
      r_data_sync <= {r_data_sync[0], i_ps2Data};
      r_clk_prev  <= r_clk_sync[1];
      r_frame_err <= w_timeout || ((r_state == ST_DONE) && !w_frame_ok);
      case (r_state)
        ST_IDLE: begin
          if (w_fall && !w_bit) begin
            r_bit_cnt <= 4'd1;
            r_shift   <= '0;
            r_stop    <= 1'b0;
            r_tmo     <= '0;
          end
        end
        ST_RECV: begin
          if (w_fall) begin
            r_tmo <= '0;
            if (r_bit_cnt == STOP_BIT_IDX) begin
              r_stop <= w_bit;
            end else begin
              // LSB first: after 9 shifts data sits in [7:0], parity in [8]
              r_shift   <= {w_bit, r_shift[8:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_tmo <= r_tmo + TIMEOUT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_byte       = r_shift[7:0];
  assign o_byteValid  = (r_state == ST_DONE) && w_frame_ok;
  assign o_frameError = r_frame_err;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 set-2 keyboard receiver: E0/F0 prefix and modifier tracking on top of the frame
// receiver, with a single-entry valid/ack output register and sticky overflow.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int TIMEOUT_BITS   = 14
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2Clk,
  input  logic       i_ps2Data,
  output logic [7:0] o_code,
  output logic       o_codeValid,
  input  logic       i_codeAck,
  output logic       o_codeBreak,
  output logic       o_codeExtended,
  output logic       o_overflow,
  output logic       o_frameError,
  output logic       o_debugShift,
  output logic       o_debugCtrl,
  output logic       o_debugAlt,
  output logic       o_debugE0,
  output logic       o_debugF0
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_emit;
  logic       w_make;

  logic       r_pend_e0, r_pend_f0;
  logic       r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
  logic [7:0] r_code;
  logic       r_valid, r_break, r_ext, r_overflow;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_BITS   (TIMEOUT_BITS)
  ) u_frame_rx (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ps2Clk     (i_ps2Clk),
    .i_ps2Data    (i_ps2Data),
    .o_byte       (w_byte),
    .o_byteValid  (w_byte_valid),
    .o_frameError (o_frameError)
  );

  assign w_emit = w_byte_valid && (w_byte != SC_E0) && (w_byte != SC_F0);
  assign w_make = !r_pend_f0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend_e0 <= 1'b0;
      r_pend_f0 <= 1'b0;
      r_lshift  <= 1'b0;
      r_rshift  <= 1'b0;
      r_lctrl   <= 1'b0;
      r_rctrl   <= 1'b0;
      r_lalt    <= 1'b0;
      r_ralt    <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte == SC_E0) begin
        r_pend_e0 <= 1'b1;
      end else if (w_byte == SC_F0) begin
        r_pend_f0 <= 1'b1;
      end else begin
        r_pend_e0 <= 1'b0;
        r_pend_f0 <= 1'b0;
        // modifiers track every emitted byte, even one later dropped by overflow
        case (w_byte)
          SC_LSHIFT: if (!r_pend_e0) r_lshift <= w_make;
          SC_RSHIFT: if (!r_pend_e0) r_rshift <= w_make;
          SC_CTRL: begin
            if (r_pend_e0) r_rctrl <= w_make;
            else           r_lctrl <= w_make;
          end
          SC_ALT: begin
            if (r_pend_e0) r_ralt <= w_make;
            else           r_lalt <= w_make;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_break    <= 1'b0;
      r_ext      <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_emit && (!r_valid || i_codeAck)) begin
      r_code  <= w_byte;
      r_break <= r_pend_f0;
      r_ext   <= r_pend_e0;
      r_valid <= 1'b1;
    end else if (w_emit) begin
      r_overflow <= 1'b1;
    end else if (r_valid && i_codeAck) begin
      r_valid <= 1'b0;
    end
  end

  assign o_code         = r_code;
  assign o_codeValid    = r_valid;
  assign o_codeBreak    = r_break;
  assign o_codeExtended = r_ext;
  assign o_overflow     = r_overflow;
  assign o_debugShift   = r_lshift | r_rshift;
  assign o_debugCtrl    = r_lctrl | r_rctrl;
  assign o_debugAlt     = r_lalt | r_ralt;
  assign o_debugE0      = r_pend_e0;
  assign o_debugF0      = r_pend_f0;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: PS/2 frames driven bit by bit, checked
// against a key-table reference model of prefixes, held keys and the output register.
module tb_ps2_keyboard_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] o_code;
  logic       o_codeValid, o_codeBreak, o_codeExtended, o_overflow, o_frameError;
  logic       o_debugShift, o_debugCtrl, o_debugAlt, o_debugE0, o_debugF0;

  int n_vec = 0;
  int n_err = 0;
  int n_fe  = 0;

  always #5 clk = ~clk;

  ps2_keyboard_receiver #(.TIMEOUT_CYCLES(200), .TIMEOUT_BITS(14)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_ps2Clk       (ps2_clk),
    .i_ps2Data      (ps2_data),
    .o_code         (o_code),
    .o_codeValid    (o_codeValid),
    .i_codeAck      (ack),
    .o_codeBreak    (o_codeBreak),
    .o_codeExtended (o_codeExtended),
    .o_overflow     (o_overflow),
    .o_frameError   (o_frameError),
    .o_debugShift   (o_debugShift),
    .o_debugCtrl    (o_debugCtrl),
    .o_debugAlt     (o_debugAlt),
    .o_debugE0      (o_debugE0),
    .o_debugF0      (o_debugF0)
  );

  always @(negedge clk) if (o_frameError) n_fe++;

  // Reference model: a table of held keys indexed by [extended][scancode]
  bit         m_held [2][256];
  bit         m_e0, m_f0, m_valid, m_brk, m_ext, m_ovf;
  logic [7:0] m_code;

  task automatic model_reset();
    foreach (m_held[i, j]) m_held[i][j] = 1'b0;
    m_e0 = 0; m_f0 = 0; m_valid = 0; m_brk = 0; m_ext = 0; m_ovf = 0;
    m_code = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ack_same);
    if (b == 8'hE0) m_e0 = 1;
    else if (b == 8'hF0) m_f0 = 1;
    else begin
      m_held[m_e0][b] = !m_f0;
      if (!m_valid || ack_same) begin
        m_valid = 1; m_code = b; m_brk = m_f0; m_ext = m_e0;
      end else begin
        m_ovf = 1;
      end
      m_e0 = 0; m_f0 = 0;
    end
  endtask

  function automatic logic [16:0] exp_vec();
    return {m_valid, m_code, m_brk, m_ext, m_ovf,
            m_held[0][8'h12] | m_held[0][8'h59],
            m_held[0][8'h14] | m_held[1][8'h14],
            m_held[0][8'h11] | m_held[1][8'h11],
            m_e0, m_f0};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {o_codeValid, o_code, o_codeBreak, o_codeExtended, o_overflow,
            o_debugShift, o_debugCtrl, o_debugAlt, o_debugE0, o_debugF0};
  endfunction

  // Drives the first nbits bits of a frame (start, 8 data LSB first, odd parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit chk_lat, input bit ack_at_emit);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (i == 10) begin
          if (ack_at_emit) ack = (j == 3);
          if (chk_lat && j == 3) begin
            n_vec++;
            if (o_codeValid !== 1'b0) begin
              n_err++;
              $display("FAIL latency_early: codeValid=%b required 0", o_codeValid);
            end
          end
          if (chk_lat && j == 4) begin
            n_vec++;
            if (o_codeValid !== 1'b1) begin
              n_err++;
              $display("FAIL latency_on_time: codeValid=%b required 1", o_codeValid);
            end
          end
        end
      end
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic do_ack();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    m_valid = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({obs_vec(), o_frameError} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {obs_vec(), o_frameError});
    end
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_make_latency();
    send_frame(8'h1C, 0, 11, 1, 0);
    model_byte(8'h1C, 0);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL make_1c: got %h required %h", obs_vec(), exp_vec());
    end
    do_ack();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL make_1c_ack: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_modifier_sequence();
    logic [7:0] seq [6] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    for (int k = 0; k < 6; k++) begin
      send_frame(seq[k], 0, 11, 0, 0);
      model_byte(seq[k], 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL modseq_%0d byte %h: got %h required %h", k, seq[k], obs_vec(), exp_vec());
      end
      do_ack();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL modseq_ack_%0d: got %h required %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [4] = '{8'hE0, 8'h12, 8'hE0, 8'h75};
    for (int k = 0; k < 4; k++) begin
      send_frame(seq[k], 0, 11, 0, 0);
      model_byte(seq[k], 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL extended_%0d byte %h: got %h required %h", k, seq[k], obs_vec(), exp_vec());
      end
      do_ack();
    end
  endtask

  task automatic test_bad_parity();
    int fe0;
    fe0 = n_fe;
    send_frame(8'h1C, 1, 11, 0, 0);
    repeat (5) @(negedge clk);
    n_vec++;
    if (n_fe - fe0 !== 1) begin
      n_err++;
      $display("FAIL parity_error_pulses: got %0d required 1", n_fe - fe0);
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL parity_no_code: got %h required %h", obs_vec(), exp_vec());
    end
    send_frame(8'h2A, 0, 11, 0, 0);
    model_byte(8'h2A, 0);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL parity_recover: got %h required %h", obs_vec(), exp_vec());
    end
    do_ack();
  endtask

  task automatic test_timeout();
    int cnt;
    send_frame(8'h5A, 0, 6, 0, 0);
    cnt = 60;  // cycles already spent since the last falling edge
    while (!o_frameError && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt < 190 || cnt > 215) begin
      n_err++;
      $display("FAIL timeout_delay: got %0d cycles required 190..215", cnt);
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL timeout_no_code: got %h required %h", obs_vec(), exp_vec());
    end
    send_frame(8'h3B, 0, 11, 0, 0);
    model_byte(8'h3B, 0);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL timeout_recover: got %h required %h", obs_vec(), exp_vec());
    end
    do_ack();
  endtask

  task automatic test_mid_frame_reset();
    send_frame(8'h4D, 0, 5, 0, 0);
    apply_reset();
    send_frame(8'h1C, 0, 11, 0, 0);
    model_byte(8'h1C, 0);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL midreset_recover: got %h required %h", obs_vec(), exp_vec());
    end
    do_ack();
  endtask

  task automatic test_overflow();
    apply_reset();
    send_frame(8'h1C, 0, 11, 0, 0);
    model_byte(8'h1C, 0);
    send_frame(8'h32, 0, 11, 0, 0);
    model_byte(8'h32, 0);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL overflow_drop: got %h required %h", obs_vec(), exp_vec());
    end
    apply_reset();
    send_frame(8'h1C, 0, 11, 0, 0);
    model_byte(8'h1C, 0);
    send_frame(8'h32, 0, 11, 0, 1);
    model_byte(8'h32, 1);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL ack_with_emit: got %h required %h", obs_vec(), exp_vec());
    end
    do_ack();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL ack_with_emit_clear: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 7))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'h12;
        3:       b = 8'h59;
        4:       b = 8'h14;
        5:       b = 8'h11;
        6:       b = 8'h1C;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, 0, 11, 0, 0);
      model_byte(b, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_%0d byte %h: got %h required %h", k, b, obs_vec(), exp_vec());
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_make_latency();
    test_modifier_sequence();
    test_extended();
    test_bad_parity();
    test_timeout();
    test_mid_frame_reset();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_keyboard_receiver.md
Name: ps2_keyboard_receiver

Overview:
- Receives PS/2 keyboard frames from the debounced ps2Clk/ps2Data lines.
- Decodes set-2 scancodes, tracking E0/F0 prefixes and the shift, ctrl and alt state.
- Presents one byte at a time to the SoC over a valid/ack handshake; also drives the debugShift/debugCtrl/debugAlt/debugE0/debugF0 flags.
- Sits between Debouncer2 and the SoC in the clkDiv domain.

Parameters:
- TIMEOUT_CYCLES, 8000: clk cycles without a ps2Clk falling edge mid-frame before the frame is aborted.
- TIMEOUT_BITS, 14: width of the timeout counter; must satisfy 2^TIMEOUT_BITS > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (clkDiv domain).
- reset  in  1  asynchronous, active-high reset.
- ps2Clk  in  1  debounced PS/2 clock; asynchronous to clk.
- ps2Data  in  1  debounced PS/2 data; asynchronous to clk.
- code  out  8  scancode byte, without prefixes.
- codeValid  out  1  code/codeBreak/codeExtended are valid; held until acknowledged.
- codeAck  in  1  consumer accepts the current code.
- codeBreak  out  1  code was preceded by F0 (key release).
- codeExtended  out  1  code was preceded by E0.
- overflow  out  1  sticky; set when a code was dropped.
- frameError  out  1  one-cycle pulse on a bad frame or timeout.
- debugShift, debugCtrl, debugAlt  out  1 each  modifier key currently held.
- debugE0, debugF0  out  1 each  prefix pending.

Behaviour:
- Reset values: every output 0; FSM in IDLE; all pending, modifier and shift-register state cleared. Reset mid-frame discards the partial frame.
- Input sync: ps2Clk and ps2Data each pass through a 2-flop synchronizer. A falling edge is prev=1 and cur=0 on the synced clock; ps2Data is sampled on the same cycle.
- Frame FSM states: IDLE, RECV, DONE.
  - IDLE: on a falling edge with data=0 (start bit), go to RECV with bitCnt=1. A start bit of 1 is ignored and the FSM stays in IDLE.
  - RECV: each falling edge shifts data in LSB-first and increments bitCnt. On the 11th bit (stop), go to DONE.
  - DONE (one cycle): frame is valid iff parity is odd over data[7:0]+parity and stop=1. Valid frame: hand the byte to the decoder. Invalid frame: pulse frameError. Either way return to IDLE.
- Timeout: in RECV only, a counter increments every clk and clears on each falling edge. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse frameError, deliver no byte.
- Decoder, per valid byte:
  - E0: set pendingE0; no output.
  - F0: set pendingF0; no output.
  - Any other byte: emit it with codeBreak=pendingF0 and codeExtended=pendingE0, then clear both pending flags.
- Modifiers, updated on every emitted byte (including dropped ones); make sets the flag, break clears it:
  - 0x12 and 0x59, non-extended only, drive separate left/right shift bits; debugShift = left OR right. E0 12 / E0 59 (fake shifts) are ignored.
  - 0x14 drives ctrl, 0x11 drives alt. Left and right variants are tracked separately and ORed.
- debugE0 = pendingE0; debugF0 = pendingF0.
- Latency: DONE is the cycle after the stop-bit edge is detected; code and codeValid are registered 1 cycle after DONE.
- Handshake:
  - codeAck with codeValid=1: codeValid drops the next cycle.
  - codeAck with codeValid=0: ignored.
  - Emit with codeValid=0: load code; codeValid=1.
  - Emit coinciding with codeAck: load the new code; codeValid stays 1.
  - Emit while codeValid=1 and no codeAck: drop the new code; set overflow, which is cleared only by reset. code is unchanged.
- Widths: bitCnt is 4 bits; the shift register is 9 bits (data + parity). Start and stop bits are checked on the fly.

Decomposition:
- Package ps2_pkg:
  - Scancode constants: SC_E0=8'hE0, SC_F0=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_ALT=8'h11.
  - Frame FSM state encoding.
- Sub-module ps2_frame_rx: synchronizer, edge detect, frame FSM, timeout. Outputs byte/byteValid/frameError.
- ps2_keyboard_receiver: prefix/modifier decoder and output handshake.

Test Plan:
- Bench setup: TIMEOUT_CYCLES=200; PS/2 half-period 40 clk.
- Make 0x1C (frame 0,00111000,parity 0,1) -> code=1C, codeValid=1, codeBreak=0, codeExtended=0; 2 cycles after the stop-edge detect. codeAck -> codeValid=0 next cycle.
- Sequence 12, 1C, F0 1C, F0 12 with ack after each emit -> debugShift rises after 12 and falls after F0 12. Third emit has code=1C, codeBreak=1. debugF0=1 between F0 and the following byte.
- E0 12 E0 75 -> first emit code=12, codeExtended=1, debugShift stays 0; second emit code=75, codeExtended=1.
- 0x1C with parity bit=1 -> frameError pulse, no codeValid; the next good frame decodes normally.
- Hold ps2Clk high after 5 bits -> frameError ~200 cycles after the last edge; FSM returns to IDLE; the next full frame is received correctly.
- Two makes (1C, 32) with no ack -> code stays 1C, overflow=1. Ack on the same cycle as the second emit instead -> code=32, codeValid stays 1, overflow=0.
